karatsuba_seq_ctrl: RTL and testbench

KARATSUBA_SEQ_CTRL -- requirements
Module: karatsuba_seq_ctrl

---
 rtl/karatsuba_seq_ctrl_pkg.sv | 16 +
 rtl/karatsuba_seq_ctrl_if.sv | 14 +
 rtl/karatsuba_seq_ctrl_mul17.sv | 12 +
 rtl/karatsuba_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_karatsuba_seq_ctrl.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/karatsuba_seq_ctrl_pkg.sv
// Shared widths and FSM state encoding for the sequential Karatsuba multiplier.
package karatsuba_seq_ctrl_pkg;

   localparam int HALF_W = 16;
   localparam int OP_W   = 2 * HALF_W;
   localparam int PROD_W = 4 * HALF_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL_LO,
      ST_MUL_HI,
      ST_MUL_MID,
      ST_COMBINE
   } state_t;

endpackage

// File: rtl/karatsuba_seq_ctrl_if.sv
// Request/result bundle of the sequential multiplier: operands in, busy/done/product out.
interface karatsuba_seq_ctrl_if #(
   parameter int HALF_W = karatsuba_seq_ctrl_pkg::HALF_W
);
   logic                  start;
   logic [2*HALF_W-1:0]   a;
   logic [2*HALF_W-1:0]   b;
   logic                  busy;
   logic                  done;
   logic [4*HALF_W-1:0]   product;

   modport master (output start, a, b, input busy, done, product);
   modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/karatsuba_seq_ctrl_mul17.sv
// Combinational unsigned W x W multiplier; sized to take the (HALF_W+1)-bit half sums.
module mul17 #(
   parameter int W = 17
) (
   input  logic [W-1:0]   x,
   input  logic [W-1:0]   y,
   output logic [2*W-1:0] p
);

   assign p = {{W{1'b0}}, x} * {{W{1'b0}}, y};

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// Sequential Karatsuba multiply on one shared multiplier; busy 4 cycles, done one cycle later.
// start is only taken in IDLE; requests while busy are dropped, not queued.
module karatsuba_seq_ctrl #(
   parameter int HALF_W = karatsuba_seq_ctrl_pkg::HALF_W
) (
   input  logic                 clk,
   input  logic                 rst,
   karatsuba_seq_ctrl_if.slave  bus
);
   import karatsuba_seq_ctrl_pkg::*;

   localparam int OW  = 2 * HALF_W;
   localparam int HSW = HALF_W + 1;
   localparam int ZW  = 2 * HSW;
   localparam int PW  = 4 * HALF_W;

   state_t          state;
   state_t          state_nxt;
   logic [OW-1:0]   op_a;
   logic [OW-1:0]   op_b;
   logic [OW-1:0]   z0;
   logic [OW-1:0]   z2;
   logic [ZW-1:0]   z1;
   logic [HSW-1:0]  mul_x;
   logic [HSW-1:0]  mul_y;
   logic [ZW-1:0]   mul_p;
   logic [ZW-1:0]   mid;
   logic [PW-1:0]   prod_sum;
   logic [PW-1:0]   product_q;
   logic            done_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:    if (bus.start) state_nxt = ST_MUL_LO;
         ST_MUL_LO:  state_nxt = ST_MUL_HI;
         ST_MUL_HI:  state_nxt = ST_MUL_MID;
         ST_MUL_MID: state_nxt = ST_COMBINE;
         ST_COMBINE: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Half sums keep their carry bit, hence the HALF_W+1 wide multiplier ports.
   always_comb begin
      mul_x = '0;
      mul_y = '0;
      unique case (state)
         ST_MUL_LO: begin
            mul_x = {1'b0, op_a[HALF_W-1:0]};
            mul_y = {1'b0, op_b[HALF_W-1:0]};
         end
         ST_MUL_HI: begin
            mul_x = {1'b0, op_a[OW-1:HALF_W]};
            mul_y = {1'b0, op_b[OW-1:HALF_W]};
         end
         ST_MUL_MID: begin
            mul_x = {1'b0, op_a[HALF_W-1:0]} + {1'b0, op_a[OW-1:HALF_W]};
            mul_y = {1'b0, op_b[HALF_W-1:0]} + {1'b0, op_b[OW-1:HALF_W]};
         end
         default: begin
         end
      endcase
   end

   mul17 #(.W(HSW)) u_mul (
      .x (mul_x),
      .y (mul_y),
      .p (mul_p)
   );

   // z1 >= z0 + z2 always holds, so the subtraction cannot wrap.
   always_comb begin
      mid      = z1 - {2'b00, z2} - {2'b00, z0};
      prod_sum = {z2, {OW{1'b0}}}
               + ({{(PW-ZW){1'b0}}, mid} << HALF_W)
               + {{OW{1'b0}}, z0};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_a      <= '0;
         op_b      <= '0;
         z0        <= '0;
         z2        <= '0;
         z1        <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= (state == ST_COMBINE);
         unique case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  op_a <= bus.a;
                  op_b <= bus.b;
               end
            end
            ST_MUL_LO:  z0 <= mul_p[OW-1:0];
            ST_MUL_HI:  z2 <= mul_p[OW-1:0];
            ST_MUL_MID: z1 <= mul_p;
            ST_COMBINE: product_q <= prod_sum;
            default: begin
            end
         endcase
      end
   end

   assign bus.busy    = (state != ST_IDLE);
   assign bus.done    = done_q;
   assign bus.product = product_q;

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Bench for karatsuba_seq_ctrl: transaction-level model checked every cycle plus directed literals.
module tb_karatsuba_seq_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests    = 0;
   int   fails    = 0;
   int   done_cnt = 0;

   karatsuba_seq_ctrl_if bus ();

   karatsuba_seq_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference: an accepted request occupies 4 busy cycles, then result and done appear together.
   int          m_remain;
   logic [63:0] m_pend;
   logic [63:0] m_prod;
   logic        m_done;
   logic        m_busy;

   assign m_busy = (m_remain != 0);

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_remain <= 0;
         m_pend   <= '0;
         m_prod   <= '0;
         m_done   <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_remain > 0) begin
            m_remain <= m_remain - 1;
            if (m_remain == 1) begin
               m_done <= 1'b1;
               m_prod <= m_pend;
            end
         end else if (bus.start) begin
            m_remain <= 4;
            m_pend   <= {32'b0, bus.a} * {32'b0, bus.b};
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("cyc busy", {63'b0, bus.busy}, {63'b0, m_busy});
      chk("cyc done", {63'b0, bus.done}, {63'b0, m_done});
      chk("cyc product", bus.product, m_prod);
      if (bus.done) done_cnt++;
   end

   // Issues one request from an idle (or done) cycle and scrambles the operands after acceptance.
   task automatic run_op(input string nm, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp);
      int lat;
      lat = 0;
      bus.start = 1'b1;
      bus.a     = x;
      bus.b     = y;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            lat = i;
            break;
         end
      end
      chk({nm, " latency"}, 64'(lat), 64'd4);
      chk({nm, " product"}, bus.product, exp);
   endtask

   initial begin
      int          d0;
      logic [31:0] rx;
      logic [31:0] ry;
      logic [63:0] re;

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      #1;
      chk("reset busy", {63'b0, bus.busy}, 64'd0);
      chk("reset done", {63'b0, bus.done}, 64'd0);
      chk("reset product", bus.product, 64'd0);
      #22 rst = 1'b1;
      @(posedge clk); #1;

      run_op("small", 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F);
      repeat (2) begin @(posedge clk); #1; end
      run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      repeat (2) begin @(posedge clk); #1; end

      // start held high while busy must not queue a second operation
      d0 = done_cnt;
      bus.start = 1'b1;
      bus.a     = 32'h0001_0000;
      bus.b     = 32'h0001_0000;
      @(posedge clk); #1;
      repeat (3) begin @(posedge clk); #1; end
      bus.start = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      chk("held start done count", 64'(done_cnt - d0), 64'd1);
      chk("held start product", bus.product, 64'h0000_0001_0000_0000);

      // back-to-back: new request issued in the done cycle
      run_op("b2b first", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
      bus.start = 1'b1;
      bus.a     = 32'd2;
      bus.b     = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("b2b busy", {63'b0, bus.busy}, 64'd1);
      chk("b2b held product", bus.product, 64'h0000_0001_0000_0000);
      repeat (3) begin @(posedge clk); #1; end
      chk("b2b no early done", {63'b0, bus.done}, 64'd0);
      @(posedge clk); #1;
      chk("b2b done", {63'b0, bus.done}, 64'd1);
      chk("b2b product", bus.product, 64'h0000_0000_0000_000E);

      // reset while in MUL_HI
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.a     = 32'h1234_5678;
      bus.b     = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      d0  = done_cnt;
      rst = 1'b0;
      #1;
      chk("rst busy", {63'b0, bus.busy}, 64'd0);
      chk("rst done", {63'b0, bus.done}, 64'd0);
      chk("rst product", bus.product, 64'd0);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      repeat (6) begin @(posedge clk); #1; end
      chk("rst no done", 64'(done_cnt - d0), 64'd0);
      run_op("after rst", 32'd6, 32'd7, 64'h0000_0000_0000_002A);

      for (int n = 0; n < 1000; n++) begin
         rx = $urandom;
         ry = $urandom;
         re = 64'(rx) * 64'(ry);
         run_op("rand", rx, ry, re);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
         end
      end

      repeat (3) begin @(posedge clk); #1; end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
